// File: rtl/saturn_pkg.sv
// Shared constants and types for the Saturn 0x-group execution slice.
// It holds the default sizes, the empty-pop value and the opcode nibbles.
package saturn_pkg;

  localparam int ADDR_W_DEF     = 20;
  localparam int RSTK_DEPTH_DEF = 8;
  localparam int CNT_W          = 4;

  localparam logic [19:0] RSTK_EMPTY_VAL = 20'h00000;

  // Second nibble of the 0x opcode group.
  typedef enum logic [3:0] {
    OP_RTNSXM = 4'h0,
    OP_RTN    = 4'h1,
    OP_RTNSC  = 4'h2,
    OP_RTNCC  = 4'h3,
    OP_SETHEX = 4'h4,
    OP_SETDEC = 4'h5,
    OP_RSTK_C = 4'h6,
    OP_C_RSTK = 4'h7
  } op0x_e;

  typedef enum logic [1:0] {
    KIND_ILLEGAL,
    KIND_RTN,
    KIND_MODE,
    KIND_RSTK
  } exec_kind_e;

  function automatic exec_kind_e decodeKind(input logic rtn, input logic setMode,
                                            input logic rstkC);
    unique case ({rtn, setMode, rstkC})
      3'b100:  return KIND_RTN;
      3'b010:  return KIND_MODE;
      3'b001:  return KIND_RSTK;
      default: return KIND_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/saturn_rstk.sv
// Hardware return stack: a circular buffer, so a push when the stack is full
// overwrites the oldest entry. A pop when the stack is empty reads zero.
module saturn_rstk
  import saturn_pkg::*;
#(
  parameter int DEPTH = RSTK_DEPTH_DEF,
  parameter int WIDTH = ADDR_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] pushData_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int              PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] topPtr;

  assign topPtr = wrPtr_q - PTR_W'(1);

  always_comb begin
    wrPtr_d = wrPtr_q;
    cnt_d   = cnt_q;
    if (push_i) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && cnt_q != '0) begin
      wrPtr_d = topPtr;
      cnt_d   = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      cnt_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset because the count alone defines what is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q] <= pushData_i;
  end

  assign top_o = (cnt_q == '0) ? WIDTH'(RSTK_EMPTY_VAL) : mem_q[topPtr];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/saturn_exec_0x.sv
// Execute stage for the Saturn 0x group: RTN family, SETHEX/SETDEC and RSTK<->C.
// It owns the return stack, carry, XM and the arithmetic mode.
module saturn_exec_0x
  import saturn_pkg::*;
#(
  parameter int RSTK_DEPTH = RSTK_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en_exec,
  input  logic              i_stalled,
  input  logic              i_ins_decoded,
  input  logic [ADDR_W-1:0] i_ins_addr,
  input  logic              i_direction,
  input  logic              i_ins_rtn,
  input  logic              i_set_xm,
  input  logic              i_set_carry,
  input  logic              i_carry_val,
  input  logic              i_ins_set_mode,
  input  logic              i_mode_dec,
  input  logic              i_ins_rstk_c,
  input  logic [ADDR_W-1:0] i_c_low,
  input  logic              i_push_req,
  input  logic [ADDR_W-1:0] i_push_addr,
  output logic              o_load_pc,
  output logic [ADDR_W-1:0] o_new_pc,
  output logic              o_c_wr,
  output logic [ADDR_W-1:0] o_c_out,
  output logic              o_carry,
  output logic              o_xm,
  output logic              o_mode_dec,
  output logic [3:0]        o_rstk_cnt,
  output logic              o_exec_done,
  output logic              o_exec_error
);

  logic              accept;
  exec_kind_e        kind;
  logic              instrTouchesStack;
  logic              stkPush, stkPop;
  logic [ADDR_W-1:0] stkPushData, stkTop;
  logic [CNT_W-1:0]  stkCnt;

  logic              loadPc_q, loadPc_d;
  logic              cWr_q, cWr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              carry_q, carry_d;
  logic              xm_q, xm_d;
  logic              modeDec_q, modeDec_d;
  logic [ADDR_W-1:0] newPc_q, newPc_d;
  logic [ADDR_W-1:0] cOut_q, cOut_d;

  // The instruction address is carried for debug visibility only.
  logic unusedInsAddr;
  assign unusedInsAddr = ^i_ins_addr;

  assign accept = i_en_exec & i_ins_decoded & ~i_stalled;
  assign kind   = decodeKind(i_ins_rtn, i_ins_set_mode, i_ins_rstk_c);
  assign instrTouchesStack = accept & ((kind == KIND_RTN) | (kind == KIND_RSTK));

  always_comb begin
    loadPc_d    = 1'b0;
    cWr_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    carry_d     = carry_q;
    xm_d        = xm_q;
    modeDec_d   = modeDec_q;
    newPc_d     = newPc_q;
    cOut_d      = cOut_q;
    stkPush     = 1'b0;
    stkPop      = 1'b0;
    stkPushData = i_c_low;

    if (accept) begin
      done_d = 1'b1;
      unique case (kind)
        KIND_RTN: begin
          stkPop   = 1'b1;
          newPc_d  = stkTop;
          loadPc_d = 1'b1;
          if (i_set_xm)    xm_d    = 1'b1;
          if (i_set_carry) carry_d = i_carry_val;
        end
        KIND_MODE: modeDec_d = i_mode_dec;
        KIND_RSTK: begin
          if (!i_direction) begin
            stkPush = 1'b1;
          end else begin
            stkPop = 1'b1;
            cOut_d = stkTop;
            cWr_d  = 1'b1;
          end
        end
        default: err_d = 1'b1;
      endcase
    end

    // A stack instruction owns the single stack port, so the external push loses.
    if (i_push_req && !i_stalled) begin
      if (instrTouchesStack) begin
        err_d = 1'b1;
      end else begin
        stkPush     = 1'b1;
        stkPushData = i_push_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      loadPc_q  <= 1'b0;
      cWr_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      carry_q   <= 1'b0;
      xm_q      <= 1'b0;
      modeDec_q <= 1'b0;
      newPc_q   <= '0;
      cOut_q    <= '0;
    end else begin
      loadPc_q  <= loadPc_d;
      cWr_q     <= cWr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      carry_q   <= carry_d;
      xm_q      <= xm_d;
      modeDec_q <= modeDec_d;
      newPc_q   <= newPc_d;
      cOut_q    <= cOut_d;
    end
  end

  saturn_rstk #(
    .DEPTH (RSTK_DEPTH),
    .WIDTH (ADDR_W)
  ) uRstk (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .push_i     (stkPush),
    .pop_i      (stkPop),
    .pushData_i (stkPushData),
    .top_o      (stkTop),
    .cnt_o      (stkCnt)
  );

  assign o_load_pc    = loadPc_q;
  assign o_new_pc     = newPc_q;
  assign o_c_wr       = cWr_q;
  assign o_c_out      = cOut_q;
  assign o_carry      = carry_q;
  assign o_xm         = xm_q;
  assign o_mode_dec   = modeDec_q;
  assign o_rstk_cnt   = stkCnt;
  assign o_exec_done  = done_q;
  assign o_exec_error = err_q;

endmodule

// File: tb/tb_saturn_exec_0x.sv
// Bench for saturn_exec_0x: directed scenarios followed by random traffic.
// All of it is checked against a queue-based reference model.
module tb_saturn_exec_0x;

  localparam int DEPTH = 8;

  logic        i_clk = 1'b0;
  logic        i_reset, i_en_exec, i_stalled, i_ins_decoded, i_direction;
  logic        i_ins_rtn, i_set_xm, i_set_carry, i_carry_val;
  logic        i_ins_set_mode, i_mode_dec, i_ins_rstk_c, i_push_req;
  logic [19:0] i_ins_addr, i_c_low, i_push_addr;
  logic        o_load_pc, o_c_wr, o_carry, o_xm, o_mode_dec, o_exec_done, o_exec_error;
  logic [19:0] o_new_pc, o_c_out;
  logic [3:0]  o_rstk_cnt;

  int errCount   = 0;
  int checkCount = 0;

  logic [19:0] stackModel[$];
  logic [19:0] expNewPc = '0, expCOut = '0;
  logic        expLoad = 0, expCwr = 0, expDone = 0;
  logic        expCarry = 0, expXm = 0, expMode = 0, expErr = 0;

  always #5 i_clk = ~i_clk;

  saturn_exec_0x #(.RSTK_DEPTH(DEPTH), .ADDR_W(20)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en_exec(i_en_exec), .i_stalled(i_stalled),
    .i_ins_decoded(i_ins_decoded), .i_ins_addr(i_ins_addr), .i_direction(i_direction),
    .i_ins_rtn(i_ins_rtn), .i_set_xm(i_set_xm), .i_set_carry(i_set_carry),
    .i_carry_val(i_carry_val), .i_ins_set_mode(i_ins_set_mode), .i_mode_dec(i_mode_dec),
    .i_ins_rstk_c(i_ins_rstk_c), .i_c_low(i_c_low), .i_push_req(i_push_req),
    .i_push_addr(i_push_addr), .o_load_pc(o_load_pc), .o_new_pc(o_new_pc),
    .o_c_wr(o_c_wr), .o_c_out(o_c_out), .o_carry(o_carry), .o_xm(o_xm),
    .o_mode_dec(o_mode_dec), .o_rstk_cnt(o_rstk_cnt), .o_exec_done(o_exec_done),
    .o_exec_error(o_exec_error)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void modelPush(input logic [19:0] v);
    stackModel.push_back(v);
    if (stackModel.size() > DEPTH) void'(stackModel.pop_front());
  endfunction

  function automatic logic [19:0] modelPop();
    if (stackModel.size() == 0) return 20'h00000;
    return stackModel.pop_back();
  endfunction

  // Reference behaviour for one clock edge, computed from the current inputs.
  task automatic modelStep();
    int   nOps;
    logic stackInstr;
    expLoad = 0; expCwr = 0; expDone = 0;
    if (i_reset) begin
      stackModel.delete();
      expNewPc = '0; expCOut = '0; expCarry = 0; expXm = 0; expMode = 0; expErr = 0;
      return;
    end
    if (i_stalled) return;
    nOps = int'(i_ins_rtn) + int'(i_ins_set_mode) + int'(i_ins_rstk_c);
    stackInstr = 0;
    if (i_en_exec && i_ins_decoded) begin
      expDone = 1;
      if (nOps != 1) begin
        expErr = 1;
      end else if (i_ins_rtn) begin
        expNewPc = modelPop();
        expLoad  = 1;
        if (i_set_xm)    expXm    = 1;
        if (i_set_carry) expCarry = i_carry_val;
        stackInstr = 1;
      end else if (i_ins_set_mode) begin
        expMode = i_mode_dec;
      end else begin
        stackInstr = 1;
        if (!i_direction) modelPush(i_c_low);
        else begin
          expCOut = modelPop();
          expCwr  = 1;
        end
      end
    end
    if (i_push_req) begin
      if (stackInstr) expErr = 1;
      else modelPush(i_push_addr);
    end
  endtask

  // Advance one cycle and compare every output with the model.
  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge i_clk);
    #1;
    checkOutput({tag, ".loadPc"}, 32'(o_load_pc),    32'(expLoad));
    checkOutput({tag, ".newPc"},  32'(o_new_pc),     32'(expNewPc));
    checkOutput({tag, ".cWr"},    32'(o_c_wr),       32'(expCwr));
    checkOutput({tag, ".cOut"},   32'(o_c_out),      32'(expCOut));
    checkOutput({tag, ".carry"},  32'(o_carry),      32'(expCarry));
    checkOutput({tag, ".xm"},     32'(o_xm),         32'(expXm));
    checkOutput({tag, ".mode"},   32'(o_mode_dec),   32'(expMode));
    checkOutput({tag, ".cnt"},    32'(o_rstk_cnt),   32'(stackModel.size()));
    checkOutput({tag, ".done"},   32'(o_exec_done),  32'(expDone));
    checkOutput({tag, ".err"},    32'(o_exec_error), 32'(expErr));
  endtask

  task automatic setIdle();
    i_reset = 0; i_en_exec = 1; i_stalled = 0; i_ins_decoded = 0; i_direction = 0;
    i_ins_rtn = 0; i_set_xm = 0; i_set_carry = 0; i_carry_val = 0;
    i_ins_set_mode = 0; i_mode_dec = 0; i_ins_rstk_c = 0; i_push_req = 0;
    i_c_low = '0; i_push_addr = '0;
  endtask

  // Sets up a legal 0x-group bundle from its opcode nibble (0..7).
  task automatic setOp(input int op, input logic [19:0] cVal);
    setIdle();
    i_ins_decoded = 1;
    i_ins_addr    = 20'h0100 + 20'(op);
    i_c_low       = cVal;
    case (op)
      0: begin i_ins_rtn = 1; i_set_xm = 1; end
      1: i_ins_rtn = 1;
      2: begin i_ins_rtn = 1; i_set_carry = 1; i_carry_val = 1; end
      3: begin i_ins_rtn = 1; i_set_carry = 1; i_carry_val = 0; end
      4: begin i_ins_set_mode = 1; i_mode_dec = 0; end
      5: begin i_ins_set_mode = 1; i_mode_dec = 1; end
      6: begin i_ins_rstk_c = 1; i_direction = 0; end
      default: begin i_ins_rstk_c = 1; i_direction = 1; end
    endcase
  endtask

  task automatic doReset();
    setIdle();
    i_reset = 1;
    applyStimulus("reset");
    i_reset = 0;
  endtask

  initial begin
    i_ins_addr = '0;
    setIdle();
    doReset();
    doReset();

    setOp(6, 20'h12345); applyStimulus("pp.push1");
    checkOutput("pp.cnt1", 32'(o_rstk_cnt), 32'd1);
    setOp(6, 20'hABCDE); applyStimulus("pp.push2");
    checkOutput("pp.cnt2", 32'(o_rstk_cnt), 32'd2);
    setOp(1, '0);        applyStimulus("pp.rtn1");
    checkOutput("pp.pc1",   32'(o_new_pc),   32'h0ABCDE);
    checkOutput("pp.load1", 32'(o_load_pc),  32'd1);
    setOp(1, '0);        applyStimulus("pp.rtn2");
    checkOutput("pp.pc2",  32'(o_new_pc),   32'h012345);
    checkOutput("pp.cnt4", 32'(o_rstk_cnt), 32'd0);
    setIdle();           applyStimulus("pp.idle");
    checkOutput("pp.loadLow", 32'(o_load_pc), 32'd0);

    for (int i = 1; i <= 9; i++) begin
      setOp(6, 20'(i)); applyStimulus("ovf.push");
    end
    checkOutput("ovf.cntFull", 32'(o_rstk_cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      setOp(7, '0); applyStimulus("ovf.pop");
      checkOutput("ovf.val", 32'(o_c_out), 32'(9 - i));
    end
    setOp(7, '0); applyStimulus("ovf.popEmpty");
    checkOutput("ovf.emptyVal", 32'(o_c_out), 32'd0);
    checkOutput("ovf.emptyWr",  32'(o_c_wr),  32'd1);

    doReset();
    setOp(3, '0); applyStimulus("udf.rtncc");
    checkOutput("udf.err", 32'(o_exec_error), 32'd0);
    setOp(2, '0); applyStimulus("udf.rtnsc");
    checkOutput("udf.carry", 32'(o_carry), 32'd1);
    setOp(0, '0); applyStimulus("udf.rtnsxm");
    checkOutput("udf.xm", 32'(o_xm), 32'd1);

    setOp(5, '0); i_stalled = 1;
    for (int i = 0; i < 3; i++) applyStimulus("stall.hold");
    checkOutput("stall.mode", 32'(o_mode_dec), 32'd0);
    i_stalled = 0; applyStimulus("stall.release");
    checkOutput("stall.modeDec", 32'(o_mode_dec), 32'd1);
    setOp(4, '0); applyStimulus("mode.hex");

    setOp(1, '0); i_ins_set_mode = 1; applyStimulus("err.bundle");
    checkOutput("err.bundleErr", 32'(o_exec_error), 32'd1);
    checkOutput("err.noLoad",    32'(o_load_pc),    32'd0);
    doReset();
    setOp(6, 20'h11111); i_push_req = 1; i_push_addr = 20'h55555;
    applyStimulus("err.collide");
    checkOutput("err.collideCnt", 32'(o_rstk_cnt), 32'd1);
    setOp(7, '0); applyStimulus("err.collidePop");
    checkOutput("err.collideVal", 32'(o_c_out), 32'h011111);

    for (int i = 0; i < 3; i++) begin
      setOp(6, 20'(32'hA0 + i)); applyStimulus("rst.push");
    end
    setOp(1, '0); i_reset = 1; applyStimulus("rst.mid");
    checkOutput("rst.cnt",  32'(o_rstk_cnt), 32'd0);
    checkOutput("rst.load", 32'(o_load_pc),  32'd0);
    setIdle(); applyStimulus("rst.after");

    for (int n = 0; n < 600; n++) begin
      setOp(int'($urandom_range(0, 7)), 20'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        i_ins_rtn      = 1'($urandom);
        i_ins_set_mode = 1'($urandom);
        i_ins_rstk_c   = 1'($urandom);
      end
      i_en_exec     = ($urandom_range(0, 7) != 0);
      i_ins_decoded = ($urandom_range(0, 7) != 0);
      i_stalled     = ($urandom_range(0, 7) == 0);
      i_push_req    = ($urandom_range(0, 5) == 0);
      i_push_addr   = 20'($urandom);
      i_reset       = ($urandom_range(0, 63) == 0);
      applyStimulus("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/saturn_exec_0x.md
Name: saturn_exec_0x

Overview:
- Execution-side counterpart of the Saturn instruction decoder: consumes the decoded-instruction bundle for the 0x group (RTN family, SETHEX/SETDEC, RSTK=C / C=RSTK) and carries out its effects.
- Owns the hardware return stack (RSTK), the carry flag, the XM status bit and the hex/dec arithmetic mode.
- Issues PC-load requests to the fetch unit and 20-bit C-register write requests to the register file.

Parameters:
- RSTK_DEPTH, 8, number of 20-bit return-stack levels (power of two, ≥2).
- ADDR_W, 20, address / RSTK entry width in bits.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_en_exec  in  1  execute phase enable
- i_stalled  in  1  global stall; when high, nothing is accepted and no state changes
- i_ins_decoded  in  1  decoded instruction valid
- i_ins_addr  in  20  address of decoded instruction (debug only)
- i_direction  in  1  0 = RSTK=C, 1 = C=RSTK
- i_ins_rtn  in  1  RTN-family instruction
- i_set_xm  in  1  RTN also sets XM
- i_set_carry  in  1  RTN also writes carry
- i_carry_val  in  1  carry value for RTNSC (1) / RTNCC (0)
- i_ins_set_mode  in  1  SETHEX/SETDEC
- i_mode_dec  in  1  1 = decimal, 0 = hex
- i_ins_rstk_c  in  1  RSTK=C / C=RSTK
- i_c_low  in  20  current C[19:0] from the register file
- i_push_req  in  1  external push (future GOSUB path)
- i_push_addr  in  20  address pushed by i_push_req
- o_load_pc  out  1  one-cycle pulse: fetch loads o_new_pc
- o_new_pc  out  20  RTN target
- o_c_wr  out  1  one-cycle pulse: write o_c_out into C[19:0]
- o_c_out  out  20  value popped for C=RSTK
- o_carry  out  1  carry flag
- o_xm  out  1  XM status bit
- o_mode_dec  out  1  arithmetic mode, 1 = decimal
- o_rstk_cnt  out  4  occupied RSTK levels, 0..RSTK_DEPTH
- o_exec_done  out  1  one-cycle pulse: instruction retired
- o_exec_error  out  1  sticky: illegal bundle or push collision

Behaviour:
- Reset:
  - All outputs are 0, including o_new_pc, o_c_out and o_rstk_cnt.
  - The stack is empty; the storage contents are don't-care.
  - Reset takes precedence over every other input, including an operation in flight.
- Accept:
  - An instruction is accepted on an edge where i_en_exec & i_ins_decoded & !i_stalled.
  - Every effect is registered and visible one cycle after the accept edge; latency is exactly 1 and there is no backpressure.
- Pulses: o_load_pc, o_c_wr and o_exec_done are high for exactly one cycle per accepted instruction and low otherwise.
- Legality:
  - Exactly one of i_ins_rtn, i_ins_set_mode and i_ins_rstk_c must be set.
  - If zero or more than one is set: set o_exec_error, change no state, assert no o_load_pc or o_c_wr; o_exec_done still pulses.
- RTN:
  - Pop; o_new_pc = popped value; pulse o_load_pc.
  - If i_set_xm, o_xm <= 1.
  - If i_set_carry, o_carry <= i_carry_val.
- SETHEX/SETDEC: o_mode_dec <= i_mode_dec.
- RSTK=C (i_direction=0): push i_c_low.
- C=RSTK (i_direction=1): pop; o_c_out = popped value; pulse o_c_wr.
- Stack semantics:
  - LIFO. Push when o_rstk_cnt == RSTK_DEPTH silently discards the oldest entry; the count stays at RSTK_DEPTH.
  - Pop when o_rstk_cnt == 0 returns 20'h00000; the count stays 0. Neither case is an error.
- External push:
  - i_push_req pushes i_push_addr on any non-stalled edge when no accepted instruction touches the stack.
  - If it coincides with an accepted RTN or RSTK instruction: the instruction wins, the push is dropped and o_exec_error is set.
  - When it coincides with an accepted SETHEX/SETDEC, both take effect.
- o_exec_error clears only on reset.

Decomposition:
- saturn_pkg holds:
  - ADDR_W and RSTK_DEPTH defaults;
  - the RSTK empty-pop value 20'h00000;
  - nibble constants for the 0x opcodes (RTNSXM=0 … C=RSTK=7).
- One sub-module, saturn_rstk, is natural:
  - Storage plus count.
  - Single push/pop port; push-when-full drop-oldest and pop-when-empty zero behaviour live here.
  - Combinational top-of-stack output, registered state.

Test Plan:
- Push/pop order: RSTK=C with C=12345 then C=ABCDE, then RTN, RTN -> o_new_pc=ABCDE then 12345; o_rstk_cnt goes 1,2,1,0; each o_load_pc is one cycle, one cycle after its accept.
- Overflow: 9 RSTK=C pushes of values 1..9, then 8 C=RSTK -> o_c_out = 9,8,…,2; o_rstk_cnt stays 8 after pushes 8 and 9; a 9th pop returns 00000 with o_c_wr=1.
- Underflow: from reset, RTNCC -> o_new_pc=00000, o_carry=0, o_rstk_cnt=0, o_exec_error=0. Then RTNSC -> o_carry=1. Then RTNSXM -> o_xm=1.
- Mode and stall: SETDEC held with i_stalled=1 for 3 cycles -> no change and no pulses; on release, o_mode_dec=1 one cycle later. SETHEX -> 0.
- Errors:
  - Bundle with i_ins_rtn=1 and i_ins_set_mode=1 -> o_exec_error=1, no o_load_pc, o_exec_done pulses.
  - i_push_req=1 (addr 55555) with an accepted RSTK=C (C=11111) -> only 11111 is stacked, o_exec_error=1.
- Reset mid-stream: 3 pushes, then i_reset for one cycle coincident with an accepted RTN -> o_rstk_cnt=0, o_load_pc=0, all flags 0 on the following cycle.
